// File: rtl/mmio_bus.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bus
// Description : Word-addressed MMIO fabric with a zero-latency RAM read port,
//               a FIFO-fed 8N1 serial transmitter and a status register.
//               Define MMIO_CYCLE_COUNTER_EN to add the CYCLE counter.
// Revision    : 1.0
// ============================================================================
module mmio_bus #(
    parameter int MEM_WORDS  = 4096,
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    output logic [31:0] cpu_rdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int          c_RAM_AW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int          c_FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          c_PTR_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int          c_CNT_W   = $clog2(CLK_DIV);
    localparam logic [31:0] c_RAM_WORDS = 32'(MEM_WORDS);
    localparam logic [29:0] c_TXDATA_W  = 30'h0400_0000;
    localparam logic [29:0] c_STATUS_W  = 30'h0400_0001;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [31:0]          r_mem [MEM_WORDS];
    logic [7:0]           r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wptr, r_rptr;
    logic                 r_ovf;
    logic [1:0]           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;
    logic                 r_tx;

    logic [29:0]          w_word;
    logic                 w_ram_hit, w_tx_hit, w_status_hit, w_wr;
    logic [c_RAM_AW-1:0]  w_ram_idx;
    logic [c_FIFO_AW-1:0] w_widx, w_ridx;
    logic                 w_fifo_full, w_fifo_empty, w_push, w_pop, w_ovf_set, w_bit_end;
    logic                 w_unused;

    assign w_word       = cpu_addr[31:2];
    assign w_unused     = ^cpu_addr[1:0];
    assign w_ram_hit    = ({2'b00, w_word} < c_RAM_WORDS);
    assign w_tx_hit     = (w_word == c_TXDATA_W);
    assign w_status_hit = (w_word == c_STATUS_W);
    assign w_ram_idx    = w_word[c_RAM_AW-1:0];
    assign w_wr         = cpu_we && resetn;

    // Pointers carry one extra wrap bit; masking keeps a 1-deep FIFO in range.
    assign w_widx       = r_wptr[c_FIFO_AW-1:0] & c_FIFO_AW'(FIFO_DEPTH - 1);
    assign w_ridx       = r_rptr[c_FIFO_AW-1:0] & c_FIFO_AW'(FIFO_DEPTH - 1);
    assign w_fifo_empty = (r_wptr == r_rptr);
    assign w_fifo_full  = ((r_wptr - r_rptr) == c_PTR_W'(FIFO_DEPTH));
    assign w_push       = w_wr && w_tx_hit && !w_fifo_full;
    assign w_ovf_set    = w_wr && w_tx_hit && w_fifo_full;
    assign w_bit_end    = (r_cnt == c_CNT_W'(CLK_DIV - 1));
    assign w_pop        = !w_fifo_empty &&
                          ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    assign tx      = r_tx;
    assign tx_busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (w_wr && w_ram_hit)
            r_mem[w_ram_idx] <= cpu_wdata;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[w_widx] <= cpu_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + c_PTR_W'(1);
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_wr && w_status_hit)
                r_ovf <= 1'b0;

            if (r_state == S_IDLE || w_bit_end)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + c_CNT_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_START;
                        r_shift <= r_fifo[w_ridx];
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_bit   <= 3'd0;
                        r_tx    <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                end
                default: begin
                    // Back-to-back frames start straight from STOP with no idle gap.
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_state <= S_START;
                            r_shift <= r_fifo[w_ridx];
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    localparam logic [29:0] c_CYCLE_W = 30'h0400_0002;
    logic [31:0] r_cycle;
    logic        w_cycle_hit;

    assign w_cycle_hit = (w_word == c_CYCLE_W);

    always_ff @(posedge clk) begin
        if (!resetn)
            r_cycle <= 32'd0;
        else if (cpu_we && w_cycle_hit)
            r_cycle <= cpu_wdata;
        else
            r_cycle <= r_cycle + 32'd1;
    end
`endif

    always_comb begin
        cpu_rdata = 32'd0;
        if (w_ram_hit)
            cpu_rdata = r_mem[w_ram_idx];
        else if (w_status_hit)
            cpu_rdata = {28'd0, r_ovf, tx_busy, w_fifo_empty, w_fifo_full};
`ifdef MMIO_CYCLE_COUNTER_EN
        else if (w_cycle_hit)
            cpu_rdata = r_cycle;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_bus
// Description : Self-checking bench for mmio_bus (RAM, serial TX, STATUS, CYCLE).
// Revision    : 1.0
// ============================================================================
module tb_mmio_bus;

    localparam int          MEM_WORDS  = 256;
    localparam int          CLK_DIV    = 4;
    localparam int          FIFO_DEPTH = 8;
    localparam int          FRAME      = 10 * CLK_DIV;
    localparam logic [31:0] A_TX = 32'h1000_0000;
    localparam logic [31:0] A_ST = 32'h1000_0004;
    localparam logic [31:0] A_CY = 32'h1000_0008;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_rdata;
    logic        tx, tx_busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram_model [MEM_WORDS];
    bit          ram_valid [MEM_WORDS];

    always #5 clk = ~clk;

    mmio_bus #(.MEM_WORDS(MEM_WORDS), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .resetn(resetn), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .tx(tx), .tx_busy(tx_busy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 8N1 line level for bit slot j of a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; cpu_we = 1'b0;
        tick(); tick();
        cpu_addr = A_ST; #1;
        checks++; if (cpu_rdata !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp %h", cpu_rdata, 32'h2); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", tx_busy); end
`ifdef MMIO_CYCLE_COUNTER_EN
        cpu_addr = A_CY; #1;
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cycle got %h exp 0", cpu_rdata); end
`endif
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_ram();
        int idx;
        logic [31:0] d;
        bus_write(32'h0000_0010, 32'hDEAD_BEEF);
        ram_model[4] = 32'hDEAD_BEEF; ram_valid[4] = 1'b1;
        cpu_addr = 32'h0000_0013; #1;
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_unaligned got %h exp DEADBEEF", cpu_rdata); end
        // A read during the write cycle must still see the old word
        cpu_addr = 32'h0000_0010; cpu_wdata = 32'h0BAD_F00D; cpu_we = 1'b1; #1;
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_old_word got %h exp DEADBEEF", cpu_rdata); end
        tick(); cpu_we = 1'b0; #1;
        ram_model[4] = 32'h0BAD_F00D;
        checks++; if (cpu_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL ram_new_word got %h exp 0BADF00D", cpu_rdata); end
        for (int k = 0; k < 24; k++) begin
            idx = (k == 0) ? MEM_WORDS - 1 : int'($urandom_range(0, MEM_WORDS - 1));
            d = $urandom;
            bus_write(32'(idx) * 32'd4 + 32'($urandom_range(0, 3)), d);
            ram_model[idx] = d; ram_valid[idx] = 1'b1;
        end
        for (int i = 0; i < MEM_WORDS; i++) begin
            if (ram_valid[i]) begin
                cpu_addr = 32'(i) * 32'd4 + 32'($urandom_range(0, 3)); #1;
                checks++; if (cpu_rdata !== ram_model[i]) begin errors++; $display("FAIL ram_word[%0d] got %h exp %h", i, cpu_rdata, ram_model[i]); end
            end
        end
        // Writes are ignored while held in reset, and reset leaves RAM alone
        bus_write(32'h0000_001C, 32'hA5A5_0007);
        ram_model[7] = 32'hA5A5_0007; ram_valid[7] = 1'b1;
        resetn = 1'b0;
        bus_write(32'h0000_001C, 32'hFFFF_FFFF);
        resetn = 1'b1;
        tick();
        cpu_addr = 32'h0000_001C; #1;
        checks++; if (cpu_rdata !== 32'hA5A5_0007) begin errors++; $display("FAIL ram_write_in_reset got %h exp A5A50007", cpu_rdata); end
    endtask

    task automatic test_tx_frame(input logic [7:0] b);
        int busy_cycles;
        logic exp_tx, exp_busy;
        busy_cycles = 0;
        bus_write(A_TX, {24'hABCDEF, b});
        cpu_addr = A_ST; #1;
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL tx_queued_status got %h exp 0", cpu_rdata); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_before_start got %b exp 1", tx); end
        for (int m = 1; m <= FRAME + 3; m++) begin
            tick();
            exp_busy = (m <= FRAME);
            exp_tx   = exp_busy ? frame_bit(b, (m - 1) / CLK_DIV) : 1'b1;
            if (tx_busy === 1'b1) busy_cycles++;
            checks++; if (tx !== exp_tx || tx_busy !== exp_busy) begin
                errors++; $display("FAIL tx_frame byte %h cycle %0d got tx=%b busy=%b exp tx=%b busy=%b", b, m, tx, tx_busy, exp_tx, exp_busy);
            end
        end
        checks++; if (busy_cycles != FRAME) begin errors++; $display("FAIL tx_busy_len got %0d exp %0d", busy_cycles, FRAME); end
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [10];
        logic [7:0] accepted [$];
        logic       ovf_m;
        int         idx, pending;
        logic       exp_tx, exp_busy;
        logic [31:0] exp_st;
        ovf_m = 1'b0;
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
        bus_write(A_TX, {24'd0, bytes[0]});
        accepted.push_back(bytes[0]);
        cpu_addr = 32'd0;
        for (int m = 1; m <= 9 * FRAME + 6; m++) begin
            tick();
            idx = (m - 1) / FRAME;
            exp_busy = (idx < accepted.size());
            exp_tx   = exp_busy ? frame_bit(accepted[idx], ((m - 1) % FRAME) / CLK_DIV) : 1'b1;
            checks++; if (tx !== exp_tx || tx_busy !== exp_busy) begin
                errors++; $display("FAIL ovf_stream cycle %0d got tx=%b busy=%b exp tx=%b busy=%b", m, tx, tx_busy, exp_tx, exp_busy);
            end
            pending = accepted.size() - 1;
            if (m <= 9) begin
                cpu_addr = A_TX; cpu_wdata = {24'd0, bytes[m]}; cpu_we = 1'b1;
                if (pending < FIFO_DEPTH) accepted.push_back(bytes[m]);
                else ovf_m = 1'b1;
            end else if (m == 10) begin
                cpu_addr = A_ST; cpu_wdata = $urandom; cpu_we = 1'b1; #1;
                exp_st = {28'd0, ovf_m, 1'b1, pending == 0, pending == FIFO_DEPTH};
                checks++; if (cpu_rdata !== exp_st) begin errors++; $display("FAIL ovf_status_set got %h exp %h", cpu_rdata, exp_st); end
                ovf_m = 1'b0;
            end else if (m == 11) begin
                cpu_addr = A_ST; cpu_we = 1'b0; #1;
                exp_st = {28'd0, ovf_m, 1'b1, pending == 0, pending == FIFO_DEPTH};
                checks++; if (cpu_rdata !== exp_st) begin errors++; $display("FAIL ovf_status_clear got %h exp %h", cpu_rdata, exp_st); end
            end else begin
                cpu_addr = 32'd0; cpu_we = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'($urandom);
        bus_write(A_TX, {24'd0, b});
        bus_write(A_TX, 32'h0000_00C3);
        cpu_addr = 32'd0;
        for (int m = 2; m <= 17; m++) tick();
        checks++; if (tx !== frame_bit(b, 4)) begin errors++; $display("FAIL mid_data_bit3 got %b exp %b", tx, frame_bit(b, 4)); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        cpu_addr = A_ST; #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx got %b exp 1", tx); end
        checks++; if (cpu_rdata !== 32'h2) begin errors++; $display("FAIL mid_reset_status got %h exp 2", cpu_rdata); end
        for (int m = 0; m < 3 * FRAME; m++) begin
            tick();
            checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin
                errors++; $display("FAIL mid_reset_quiet cycle %0d got tx=%b busy=%b exp tx=1 busy=0", m, tx, tx_busy);
            end
        end
    endtask

    task automatic test_unmapped();
        bus_write(32'h0000_0000, 32'h1234_5678);
        cpu_addr = 32'h2000_0000; #1;
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", cpu_rdata); end
        cpu_addr = A_TX; #1;
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL txdata_read got %h exp 0", cpu_rdata); end
        cpu_addr = 32'(MEM_WORDS) * 32'd4; #1;
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL past_ram_read got %h exp 0", cpu_rdata); end
        bus_write(32'h2000_0000, 32'hFFFF_FFFF);
        bus_write(32'(MEM_WORDS) * 32'd4, 32'hFFFF_FFFF);
        cpu_addr = 32'h0000_0000; #1;
        checks++; if (cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL unmapped_ram0 got %h exp 12345678", cpu_rdata); end
        cpu_addr = A_ST; #1;
        checks++; if (cpu_rdata !== 32'h2) begin errors++; $display("FAIL unmapped_status got %h exp 2", cpu_rdata); end
    endtask

    task automatic test_cycle();
`ifdef MMIO_CYCLE_COUNTER_EN
        logic [31:0] v;
        cpu_addr = A_CY; #1;
        v = cpu_rdata;
        tick();
        checks++; if (cpu_rdata !== v + 32'd1) begin errors++; $display("FAIL cycle_incr got %h exp %h", cpu_rdata, v + 32'd1); end
        bus_write(A_CY, 32'hFFFF_FFFE);
        #1;
        checks++; if (cpu_rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cycle_load got %h exp FFFFFFFE", cpu_rdata); end
        tick();
        checks++; if (cpu_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_plus1 got %h exp FFFFFFFF", cpu_rdata); end
        tick();
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL cycle_wrap got %h exp 0", cpu_rdata); end
`else
        cpu_addr = A_CY; #1;
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL cycle_absent_read got %h exp 0", cpu_rdata); end
        bus_write(A_CY, 32'hFFFF_FFFE);
        #1;
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL cycle_absent_write got %h exp 0", cpu_rdata); end
`endif
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tx_frame(8'h55);
        test_tx_frame(8'($urandom));
        test_overflow();
        test_reset_midframe();
        test_unmapped();
        test_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
